pipeline_latch_bank: RTL and testbench

Parametrised bank of NSTAGES pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB, ...) with built-in stall propagation, bubble insertion, per-stage flush, and valid tracking. It replaces hand-written per-signal stage registers: each stage's field bundle is packed into one WIDTH-bit payload. Hazard and branch logic drive stall/flush requests; the bank resolves priorities and reports the upstream hold for the PC. Two saturating counters record bubble and flush events for performance analysis.

---
 rtl/pipeline_latch_bank.sv | 127 ++++++++++++
 tb/tb_pipeline_latch_bank.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_latch_bank.sv
// pipeline_latch_bank
//
// Bank of NSTAGES pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB, ...).
// Each latch holds one packed WIDTH-bit payload and a valid bit. The bank
// resolves stall/flush requests into per-latch hold, flush and bubble
// actions. It also counts bubble and flush cycles for performance analysis.
//
// Ports
//   CLK            clock, rising edge
//   nRST           asynchronous active-low reset
//   d_in           next payload for latch i at [i*WIDTH +: WIDTH]
//   v_in           next valid bit for latch i
//   stall_req      bit i: latch i keeps its contents this cycle
//   flush_req      bit i: latch i loads a bubble this cycle
//   cnt_clr        synchronous clear of both event counters
//   q_data         registered payload of latch i at [i*WIDTH +: WIDTH]
//   q_valid        registered valid bit of latch i
//   hold_vec       combinational effective hold per latch
//   upstream_hold  combinational hold for PC/fetch (hold_vec[0])
//   bubble_cnt     saturating count of cycles that inserted a stall bubble
//   flush_cnt      saturating count of cycles with any flush request
module pipeline_latch_bank #(
    parameter int              WIDTH   = 32,
    parameter int              NSTAGES = 4,
    parameter logic [WIDTH-1:0] NOP_VAL = '0,
    parameter int              COUNT_W = 16
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NSTAGES*WIDTH-1:0]   d_in,
    input  logic [NSTAGES-1:0]         v_in,
    input  logic [NSTAGES-1:0]         stall_req,
    input  logic [NSTAGES-1:0]         flush_req,
    input  logic                       cnt_clr,
    output logic [NSTAGES*WIDTH-1:0]   q_data,
    output logic [NSTAGES-1:0]         q_valid,
    output logic [NSTAGES-1:0]         hold_vec,
    output logic                       upstream_hold,
    output logic [COUNT_W-1:0]         bubble_cnt,
    output logic [COUNT_W-1:0]         flush_cnt
);

    logic [NSTAGES*WIDTH-1:0] data_p0;
    logic [NSTAGES-1:0]       vld_p0;
    logic [NSTAGES-1:0]       bubble_vec;
    logic                     bubble_evt;
    logic                     flush_evt;
    logic [COUNT_W-1:0]       bubble_cnt_p0;
    logic [COUNT_W-1:0]       flush_cnt_p0;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        if (&c)
            return c;
        else
            return c + 1'b1;
    endfunction

    // A stalled latch freezes everything upstream of it, so the hold for
    // latch i is the OR of all stall requests at or downstream of i.
    always_comb begin
        logic acc;
        acc = 1'b0;
        hold_vec = '0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            acc = acc | stall_req[i];
            hold_vec[i] = acc;
        end
    end

    assign upstream_hold = hold_vec[0];

    // A bubble appears in a free latch whose upstream neighbour is held.
    // Latch 0 has no upstream latch; fetch is frozen through upstream_hold.
    // A flushed latch already loads NOP, so it does not count as a bubble.
    always_comb begin
        bubble_vec = '0;
        for (int i = 1; i < NSTAGES; i++) begin
            bubble_vec[i] = ~flush_req[i] & ~hold_vec[i] & hold_vec[i-1];
        end
    end

    assign bubble_evt = |bubble_vec;
    assign flush_evt  = |flush_req;

    // ---- latch stage: flush > hold > bubble > load ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSTAGES; i++) begin
                data_p0[i*WIDTH +: WIDTH] <= NOP_VAL;
            end
            vld_p0 <= '0;
        end else begin
            for (int i = 0; i < NSTAGES; i++) begin
                if (flush_req[i] || bubble_vec[i]) begin
                    data_p0[i*WIDTH +: WIDTH] <= NOP_VAL;
                    vld_p0[i]                 <= 1'b0;
                end else if (!hold_vec[i]) begin
                    data_p0[i*WIDTH +: WIDTH] <= d_in[i*WIDTH +: WIDTH];
                    vld_p0[i]                 <= v_in[i];
                end
            end
        end
    end

    // ---- event counter stage: clear beats increment ----
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bubble_cnt_p0 <= '0;
            flush_cnt_p0  <= '0;
        end else if (cnt_clr) begin
            bubble_cnt_p0 <= '0;
            flush_cnt_p0  <= '0;
        end else begin
            if (bubble_evt)
                bubble_cnt_p0 <= sat_inc(bubble_cnt_p0);
            if (flush_evt)
                flush_cnt_p0 <= sat_inc(flush_cnt_p0);
        end
    end

    assign q_data     = data_p0;
    assign q_valid    = vld_p0;
    assign bubble_cnt = bubble_cnt_p0;
    assign flush_cnt  = flush_cnt_p0;

endmodule

// File: tb/tb_pipeline_latch_bank.sv
module tb_pipeline_latch_bank;

    localparam int WIDTH   = 32;
    localparam int NSTAGES = 4;
    localparam int COUNT_W = 4;

    logic                     CLK;
    logic                     nRST;
    logic [NSTAGES*WIDTH-1:0] d_in;
    logic [NSTAGES-1:0]       v_in;
    logic [NSTAGES-1:0]       stall_req;
    logic [NSTAGES-1:0]       flush_req;
    logic                     cnt_clr;
    logic [NSTAGES*WIDTH-1:0] q_data;
    logic [NSTAGES-1:0]       q_valid;
    logic [NSTAGES-1:0]       hold_vec;
    logic                     upstream_hold;
    logic [COUNT_W-1:0]       bubble_cnt;
    logic [COUNT_W-1:0]       flush_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_latch_bank #(
        .WIDTH  (WIDTH),
        .NSTAGES(NSTAGES),
        .NOP_VAL('0),
        .COUNT_W(COUNT_W)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .d_in         (d_in),
        .v_in         (v_in),
        .stall_req    (stall_req),
        .flush_req    (flush_req),
        .cnt_clr      (cnt_clr),
        .q_data       (q_data),
        .q_valid      (q_valid),
        .hold_vec     (hold_vec),
        .upstream_hold(upstream_hold),
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST      = 1'b1;
        d_in      = '0;
        v_in      = '0;
        stall_req = '0;
        flush_req = '0;
        cnt_clr   = 1'b0;

        // Reset state, before any clock edge
        #1 nRST = 1'b0;
        #2;
        chk("rst_q_data", q_data, 128'h0);
        chk("rst_q_valid", q_valid, 4'b0000);
        chk("rst_bcnt", bubble_cnt, 4'd0);
        chk("rst_fcnt", flush_cnt, 4'd0);
        step();
        nRST = 1'b1;

        // Free flow
        d_in = {32'h44, 32'h33, 32'h22, 32'h11};
        v_in = 4'b1111;
        #1;
        chk("free_hold_vec", hold_vec, 4'b0000);
        chk("free_uphold", upstream_hold, 1'b0);
        step();
        chk("free_q_data", q_data, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("free_q_valid", q_valid, 4'b1111);

        // Stall at latch 2 for 3 cycles: bubbles at latch 3
        d_in      = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
        stall_req = 4'b0100;
        #1;
        chk("stall_hold_vec", hold_vec, 4'b0111);
        chk("stall_uphold", upstream_hold, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_q_data", q_data, {32'h0, 32'h33, 32'h22, 32'h11});
            chk("stall_q_valid", q_valid, 4'b0111);
        end
        chk("stall_bcnt", bubble_cnt, 4'd3);
        chk("stall_fcnt", flush_cnt, 4'd0);

        // Flush latch 0 while latch 1 stalls
        stall_req = 4'b0010;
        flush_req = 4'b0001;
        #1;
        chk("fvh_hold_vec", hold_vec, 4'b0011);
        step();
        chk("fvh_q_data", q_data, {32'hA4, 32'h0, 32'h22, 32'h0});
        chk("fvh_q_valid", q_valid, 4'b1010);
        chk("fvh_fcnt", flush_cnt, 4'd1);
        chk("fvh_bcnt", bubble_cnt, 4'd4);

        // Full freeze
        stall_req = 4'b1000;
        flush_req = 4'b0000;
        d_in      = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
        #1;
        chk("frz_hold_vec", hold_vec, 4'b1111);
        step();
        chk("frz_q_data", q_data, {32'hA4, 32'h0, 32'h22, 32'h0});
        chk("frz_q_valid", q_valid, 4'b1010);
        chk("frz_bcnt", bubble_cnt, 4'd4);

        // Flush beats hold on the frozen last latch
        flush_req = 4'b1000;
        step();
        chk("fbh_q_data", q_data, {32'h0, 32'h0, 32'h22, 32'h0});
        chk("fbh_q_valid", q_valid, 4'b0010);
        chk("fbh_fcnt", flush_cnt, 4'd2);
        chk("fbh_bcnt", bubble_cnt, 4'd4);

        // Payload captured even with valid low
        stall_req = 4'b0000;
        flush_req = 4'b0000;
        d_in      = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
        v_in      = 4'b0101;
        step();
        chk("vlo_q_data", q_data, {32'hB4, 32'hB3, 32'hB2, 32'hB1});
        chk("vlo_q_valid", q_valid, 4'b0101);

        // Saturation: 20 bubble cycles from a stall at latch 0
        stall_req = 4'b0001;
        for (int k = 0; k < 20; k++) step();
        chk("sat_bcnt", bubble_cnt, 4'd15);
        chk("sat_q_data", q_data, {32'hB4, 32'hB3, 32'h0, 32'hB1});
        cnt_clr = 1'b1;
        step();
        chk("clr_bcnt", bubble_cnt, 4'd0);
        chk("clr_fcnt", flush_cnt, 4'd0);
        cnt_clr = 1'b0;
        step();
        chk("clr_next_bcnt", bubble_cnt, 4'd1);

        // Asynchronous reset mid-cycle with latches loaded and a stall pending
        stall_req = 4'b0000;
        d_in      = {32'h44, 32'h33, 32'h22, 32'h11};
        v_in      = 4'b1111;
        step();
        stall_req = 4'b0100;
        #2 nRST = 1'b0;
        #1;
        chk("arst_q_data", q_data, 128'h0);
        chk("arst_q_valid", q_valid, 4'b0000);
        chk("arst_bcnt", bubble_cnt, 4'd0);
        chk("arst_fcnt", flush_cnt, 4'd0);
        step();
        nRST      = 1'b1;
        stall_req = 4'b0000;
        d_in      = {32'h54, 32'h53, 32'h52, 32'h51};
        step();
        chk("post_rst_q_data", q_data, {32'h54, 32'h53, 32'h52, 32'h51});
        chk("post_rst_bcnt", bubble_cnt, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
